// File: rtl/pir_alarm_ctrl_n_pkg.sv
// pir_pkg: shared types for the PIR alarm controller.
//   state_t      one-hot controller state
//   log_entry_w  width of one event-log entry ({detect mask, max sample})
package pir_pkg;

  typedef enum logic [3:0] {
    INIT  = 4'b0001,
    IDLE  = 4'b0010,
    ALARM = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  function automatic int log_entry_w(input int num_sensors, input int sample_w);
    return num_sensors + sample_w;
  endfunction

endpackage

// File: rtl/pir_event_log.sv
// pir_event_log: synchronous FIFO with show-ahead read data.
//   clk, rst_n  clock / synchronous active-low reset
//   clr         drop all entries (pointers and count to 0)
//   push        write wr_data; ignored when full unless a pop happens too
//   pop         advance head; ignored when empty
//   rd_data     head entry, 0 while empty
//   full/empty/count  occupancy
// Drop-on-full accounting is the parent's job.
module pir_event_log #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !clr;
  // a pop in the same cycle frees the slot the push needs
  assign do_push = push && !clr && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CNW'(do_push) - CNW'(do_pop);
    end
  end

endmodule

// File: rtl/pir_alarm_ctrl_n.sv
// pir_alarm_ctrl_n: NUM_SENSORS-channel PIR alarm controller.
//   clk, rst_n     clock / synchronous active-low reset
//   enable         arm switch, 0 returns to INIT and clears everything
//   stop_alarm     operator acknowledge, ends an alarm early
//   sensor_data    packed samples, channel i at [i*SAMPLE_W +: SAMPLE_W]
//   led, buzzer    alarm indicators (registered)
//   trig_count     popcount of led
//   peak_value/peak_sensor  largest alarm-time sample and its 1-based channel
//   log_*          event log read side: {mask, max sample} per alarm
module pir_alarm_ctrl_n
  import pir_pkg::*;
#(
  parameter int NUM_SENSORS  = 3,
  parameter int SAMPLE_W     = 7,
  parameter int THRESHOLD    = 50,
  parameter int DEBOUNCE     = 2,
  parameter int ALARM_CYCLES = 100,
  parameter int LOG_DEPTH    = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                stop_alarm,
  input  logic [NUM_SENSORS*SAMPLE_W-1:0]     sensor_data,
  output logic [NUM_SENSORS-1:0]              led,
  output logic                                buzzer,
  output logic [$clog2(NUM_SENSORS+1)-1:0]    trig_count,
  output logic [SAMPLE_W-1:0]                 peak_value,
  output logic [$clog2(NUM_SENSORS+1)-1:0]    peak_sensor,
  input  logic                                log_rd_en,
  output logic [NUM_SENSORS+SAMPLE_W-1:0]     log_rd_data,
  output logic                                log_empty,
  output logic [$clog2(LOG_DEPTH+1)-1:0]      log_count,
  output logic                                log_overflow
);

  localparam int CW  = $clog2(NUM_SENSORS+1);
  localparam int TW  = $clog2(ALARM_CYCLES);
  localparam int DW  = $clog2(DEBOUNCE+1);
  localparam int LW  = log_entry_w(NUM_SENSORS, SAMPLE_W);
  localparam logic [31:0] THR = 32'(THRESHOLD);

  state_t                                   state;
  logic [NUM_SENSORS-1:0][SAMPLE_W-1:0]     samp;
  logic [DW-1:0]                            cnt [NUM_SENSORS];
  logic [NUM_SENSORS-1:0]                   hit, det;
  logic [SAMPLE_W-1:0]                      cand_val;
  logic [CW-1:0]                            cand_idx;
  logic [TW-1:0]                            timer;
  logic                                     log_push, log_clr, log_full;
  logic [LW-1:0]                            log_wdata;

  assign samp = sensor_data;

  // per-channel hit / detect; THRESHOLD may exceed the sample range
  always_comb begin
    for (int i = 0; i < NUM_SENSORS; i++) begin
      hit[i] = (32'(samp[i]) >= THR);
      det[i] = (cnt[i] == DW'(DEBOUNCE));
    end
  end

  // debounce counters only run while armed; INIT/STOP force a fresh count
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (!rst_n || !(state == IDLE || state == ALARM) || !hit[i])
        cnt[i] <= '0;
      else if (cnt[i] != DW'(DEBOUNCE))
        cnt[i] <= cnt[i] + 1'b1;
    end
  end

  // strict > keeps the lowest index on ties
  always_comb begin
    cand_val = '0;
    cand_idx = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (samp[i] > cand_val) begin
        cand_val = samp[i];
        cand_idx = CW'(i + 1);
      end
    end
  end

  always_comb begin
    trig_count = '0;
    for (int i = 0; i < NUM_SENSORS; i++) trig_count = trig_count + CW'(led[i]);
  end

  assign log_push  = enable && (state == IDLE) && (|det);
  assign log_clr   = !enable || (state == INIT);
  assign log_wdata = {det, cand_val};

  pir_event_log #(.WIDTH(LW), .DEPTH(LOG_DEPTH)) u_log (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (log_clr),
    .push    (log_push),
    .pop     (log_rd_en),
    .wr_data (log_wdata),
    .rd_data (log_rd_data),
    .full    (log_full),
    .empty   (log_empty),
    .count   (log_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= INIT;
      led          <= '0;
      buzzer       <= 1'b0;
      timer        <= '0;
      peak_value   <= '0;
      peak_sensor  <= '0;
      log_overflow <= 1'b0;
    end else if (!enable) begin
      state        <= INIT;
      led          <= '0;
      buzzer       <= 1'b0;
      timer        <= '0;
      peak_value   <= '0;
      peak_sensor  <= '0;
      log_overflow <= 1'b0;
    end else begin
      // a push into a full log survives only if the head is popped this cycle
      if (log_push && log_full && !log_rd_en) log_overflow <= 1'b1;
      unique case (state)
        INIT: begin
          state        <= IDLE;
          led          <= '0;
          buzzer       <= 1'b0;
          peak_value   <= '0;
          peak_sensor  <= '0;
          log_overflow <= 1'b0;
        end
        IDLE: begin
          if (|det) begin
            state  <= ALARM;
            buzzer <= 1'b1;
            led    <= det;
            timer  <= '0;
            if (cand_val > peak_value) begin
              peak_value  <= cand_val;
              peak_sensor <= cand_idx;
            end
          end
        end
        ALARM: begin
          led   <= led | det;
          timer <= timer + 1'b1;
          if (cand_val > peak_value) begin
            peak_value  <= cand_val;
            peak_sensor <= cand_idx;
          end
          if (stop_alarm || timer == TW'(ALARM_CYCLES-1)) begin
            state  <= STOP;
            buzzer <= 1'b0;
            led    <= '0;
          end
        end
        STOP:    state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pir_alarm_ctrl_n.sv
module tb_pir_alarm_ctrl_n;

  localparam int NS = 3, SW = 7, THR = 50, DB = 2, AC = 100, LD = 8;
  localparam int LW = NS + SW, CW = $clog2(NS+1), LCW = $clog2(LD+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, stop_alarm = 1'b0, log_rd_en = 1'b0;
  logic [NS*SW-1:0] sensor_data = '0;
  logic [NS-1:0]  led;
  logic           buzzer;
  logic [CW-1:0]  trig_count, peak_sensor;
  logic [SW-1:0]  peak_value;
  logic [LW-1:0]  log_rd_data;
  logic           log_empty, log_overflow;
  logic [LCW-1:0] log_count;

  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pir_alarm_ctrl_n #(
    .NUM_SENSORS(NS), .SAMPLE_W(SW), .THRESHOLD(THR),
    .DEBOUNCE(DB), .ALARM_CYCLES(AC), .LOG_DEPTH(LD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stop_alarm(stop_alarm),
    .sensor_data(sensor_data), .led(led), .buzzer(buzzer),
    .trig_count(trig_count), .peak_value(peak_value), .peak_sensor(peak_sensor),
    .log_rd_en(log_rd_en), .log_rd_data(log_rd_data), .log_empty(log_empty),
    .log_count(log_count), .log_overflow(log_overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_s(input int a, input int b, input int c);
    sensor_data = {SW'(c), SW'(b), SW'(a)};
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_INIT, M_IDLE, M_ALARM, M_STOP} mode_t;
  mode_t          m_mode = M_INIT;
  int             m_run [NS];
  logic [NS-1:0]  m_led = '0;
  bit             m_buzz = 1'b0, m_ovf = 1'b0;
  int             m_peak = 0, m_psens = 0, m_age = 0;
  logic [LW-1:0]  m_log [$];

  always @(posedge clk) begin : model
    int s [NS];
    logic [NS-1:0] dmask;
    int mx, mi;
    bit armed;
    for (int i = 0; i < NS; i++) begin
      s[i]     = int'(sensor_data[i*SW +: SW]);
      dmask[i] = (m_run[i] >= DB);
    end
    mx = 0;
    foreach (s[i]) if (s[i] > mx) mx = s[i];
    mi = 0;
    for (int i = NS-1; i >= 0; i--) if (s[i] == mx) mi = i + 1;
    if (!rst_n) begin
      m_mode = M_INIT; m_led = '0; m_buzz = 0; m_peak = 0; m_psens = 0;
      m_ovf = 0; m_age = 0; m_log.delete();
      foreach (m_run[i]) m_run[i] = 0;
    end else begin
      if (!enable || m_mode == M_INIT) begin
        m_log.delete();
        m_ovf = 0;
      end else begin
        if (log_rd_en && m_log.size() > 0) void'(m_log.pop_front());
        if (m_mode == M_IDLE && dmask != 0) begin
          if (m_log.size() < LD) m_log.push_back({dmask, mx[SW-1:0]});
          else m_ovf = 1;
        end
      end
      armed = (m_mode == M_IDLE || m_mode == M_ALARM);
      foreach (m_run[i]) m_run[i] = (armed && s[i] >= THR) ? ((m_run[i] < DB) ? m_run[i] + 1 : DB) : 0;
      if (!enable) begin
        m_mode = M_INIT; m_led = '0; m_buzz = 0; m_peak = 0; m_psens = 0;
      end else begin
        case (m_mode)
          M_INIT: m_mode = M_IDLE;
          M_IDLE: if (dmask != 0) begin
            m_mode = M_ALARM; m_buzz = 1; m_led = dmask; m_age = 0;
            if (mx > m_peak) begin m_peak = mx; m_psens = mi; end
          end
          M_ALARM: begin
            m_led = m_led | dmask;
            if (mx > m_peak) begin m_peak = mx; m_psens = mi; end
            if (stop_alarm || m_age == AC-1) begin
              m_mode = M_STOP; m_buzz = 0; m_led = '0;
            end else m_age++;
          end
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("buzzer", buzzer, m_buzz);
      chk("led", led, m_led);
      chk("trig_count", trig_count, $countones(m_led));
      chk("peak_value", peak_value, m_peak);
      chk("peak_sensor", peak_sensor, m_psens);
      chk("log_empty", log_empty, m_log.size() == 0);
      chk("log_count", log_count, m_log.size());
      chk("log_overflow", log_overflow, m_ovf);
      if (m_log.size() > 0) chk("log_rd_data", log_rd_data, m_log[0]);
    end
  end

  task automatic fire(input int k);
    int v [NS];
    foreach (v[i]) v[i] = 0;
    v[k % NS] = 55 + k;
    set_s(v[0], v[1], v[2]);
    tick(3);
    stop_alarm = 1'b1;
    set_s(0, 0, 0);
    tick(1);
    stop_alarm = 1'b0;
    tick(2);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [2:0]    mk;
    logic [LW-1:0] ent;
    logic [LW-1:0] exp_q [$];
    int            bz;

    set_s(0, 0, 0);
    tick(1);
    chk_on = 1'b1;
    tick(2);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_led", led, 0);
    chk("rst_log_empty", log_empty, 1);
    chk("rst_peak_sensor", peak_sensor, 0);
    chk("rst_log_count", log_count, 0);

    // 1: armed, quiet sensors
    rst_n = 1'b1; enable = 1'b1;
    tick(20);
    chk("t1_buzzer", buzzer, 0);
    chk("t1_log_empty", log_empty, 1);
    chk("t1_peak_sensor", peak_sensor, 0);

    // 2: channel 1 sustained -> alarm on third edge, 100-cycle window
    set_s(10, 60, 10);
    tick(2);
    chk("t2_not_yet", buzzer, 0);
    tick(1);
    chk("t2_buzzer", buzzer, 1);
    chk("t2_led", led, 3'b010);
    chk("t2_trig", trig_count, 1);
    ent = {3'b010, 7'd60};
    chk("t2_log_entry", log_rd_data, ent);
    chk("t2_peak", peak_value, 60);
    chk("t2_peak_sensor", peak_sensor, 2);
    set_s(10, 10, 10);
    bz = 0;
    for (int i = 0; i < 150; i++) begin
      if (buzzer) bz++;
      tick(1);
    end
    chk("t2_alarm_len", bz, 100);

    // 3: single hit and sub-threshold level do not alarm
    set_s(50, 10, 10); tick(1);
    set_s(10, 10, 10); tick(5);
    chk("t3_single_hit", buzzer, 0);
    set_s(49, 10, 10); tick(10);
    chk("t3_below_thr", buzzer, 0);

    // 4: mid-alarm escalation, tie to lowest channel, early stop
    set_s(10, 60, 10); tick(3);
    set_s(90, 60, 90); tick(3);
    chk("t4_led", led, 3'b111);
    chk("t4_trig", trig_count, 3);
    chk("t4_peak", peak_value, 90);
    chk("t4_peak_sensor", peak_sensor, 1);
    stop_alarm = 1'b1; set_s(0, 0, 0);
    tick(1);
    stop_alarm = 1'b0;
    chk("t4_stop_buzzer", buzzer, 0);
    chk("t4_stop_led", led, 0);
    tick(2);

    // 5: drain, overflow, ordered read-out, push+pop at full
    chk("t5_count_pre", log_count, 2);
    log_rd_en = 1'b1; tick(2); log_rd_en = 1'b0;
    chk("t5_drained", log_empty, 1);
    exp_q.delete();
    for (int k = 0; k < 9; k++) begin
      mk = 3'b001 << (k % NS);
      exp_q.push_back({mk, SW'(55 + k)});
      fire(k);
    end
    chk("t5_count_full", log_count, 8);
    chk("t5_overflow", log_overflow, 1);
    for (int j = 0; j < 8; j++) begin
      chk("t5_read_order", log_rd_data, exp_q[j]);
      log_rd_en = 1'b1; tick(1); log_rd_en = 1'b0;
    end
    chk("t5_empty_after", log_empty, 1);
    enable = 1'b0; tick(1); enable = 1'b1; tick(1);
    chk("t5_ovf_cleared", log_overflow, 0);
    chk("t5_peak_cleared", peak_value, 0);
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      mk = 3'b001 << (k % NS);
      exp_q.push_back({mk, SW'(55 + k)});
      fire(k);
    end
    set_s(0, 0, 63);
    tick(2);
    log_rd_en = 1'b1; tick(1); log_rd_en = 1'b0;
    chk("t5_pushpop_count", log_count, 8);
    chk("t5_pushpop_ovf", log_overflow, 0);
    chk("t5_pushpop_head", log_rd_data, exp_q[1]);

    // 6: disarm and reset mid-alarm
    set_s(0, 0, 0);
    enable = 1'b0; tick(1);
    chk("t6_dis_buzzer", buzzer, 0);
    chk("t6_dis_led", led, 0);
    chk("t6_dis_log", log_count, 0);
    chk("t6_dis_peak", peak_value, 0);
    chk("t6_dis_psens", peak_sensor, 0);
    enable = 1'b1; tick(1);
    set_s(10, 60, 10); tick(3);
    chk("t6_alarm", buzzer, 1);
    rst_n = 1'b0; tick(1);
    chk("t6_rst_buzzer", buzzer, 0);
    chk("t6_rst_led", led, 0);
    chk("t6_rst_log", log_empty, 1);
    chk("t6_rst_peak", peak_value, 0);
    rst_n = 1'b1; set_s(0, 0, 0);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
